btn_cond_array: RTL and testbench

BTN_COND_ARRAY -- requirements
Module: btn_cond_array

---
 rtl/btn_pkg.sv | 29 ++
 rtl/btn_chan.sv | 145 ++++++++++++++
 rtl/btn_cond_array.sv | 76 +++++++
 tb/tb_btn_cond_array.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared types and default timing for the button conditioning array.
//   btn_state_e : per-channel repeat FSM state (RELEASED, DELAY, REPEAT)
//   DEF_*       : default parameter values (timing at a 25 MHz pixel clock)
//   cnt_width() : counter width for a given terminal count
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2
    } btn_state_e;

    localparam int DEF_N_CH        = 5;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 250000;    // 10 ms
    localparam int DEF_REP_DELAY   = 12500000;  // 0.5 s
    localparam int DEF_REP_PERIOD  = 3750000;   // 0.15 s
    localparam int DEF_ONE_HOT     = 1;

    // $clog2 of the limit, never below one bit so a limit of 1 still
    // yields a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// ---------------------------------------------------------------------------
// btn_chan
// One button channel: input synchroniser, debouncer and auto-repeat FSM.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   btn_in     : raw asynchronous button pin
//   rep_en     : auto-repeat enable (synchronous)
//   pulse_req  : combinational pulse request, registered by the parent
//                after arbitration
//   lvl_next   : debounced level as it will be after this edge
//   key_lvl    : registered debounced level
// ---------------------------------------------------------------------------
module btn_chan
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_PERIOD  = DEF_REP_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic rep_en,
    output logic pulse_req,
    output logic lvl_next,
    output logic key_lvl
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("btn_chan: SYNC_STAGES must be in 2..4");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("btn_chan: DEB_CYCLES must be at least 1");
    end
    // Two consecutive pulses would otherwise be possible on one channel.
    if (REP_PERIOD < 2 || REP_DELAY < 2) begin : g_bad_rep
        $error("btn_chan: REP_PERIOD and REP_DELAY must be at least 2");
    end

    localparam int REP_LIMIT = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int DEB_W     = cnt_width(DEB_CYCLES);
    localparam int REP_W     = cnt_width(REP_LIMIT);

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] DLY_MAX = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PER_MAX = REP_W'(REP_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   lvl_q, lvl_d;
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    btn_state_e             state_q, state_d;

    logic sync_in;
    assign sync_in = sync_q[SYNC_STAGES-1];

    // Synchroniser and debouncer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
        deb_cnt_d = '0;
        lvl_d     = lvl_q;
        if (sync_in != lvl_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                lvl_d = ~lvl_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Repeat FSM. It looks at lvl_d so the press pulse is registered on the
    // same edge that key_lvl rises.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pulse_req = 1'b0;
        if (lvl_q && !lvl_d) begin
            state_d   = RELEASED;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                RELEASED: begin
                    if (!lvl_q && lvl_d) begin
                        state_d   = DELAY;
                        rep_cnt_d = '0;
                        pulse_req = 1'b1;
                    end
                end
                DELAY: begin
                    if (!rep_en) begin
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == DLY_MAX) begin
                        state_d   = REPEAT;
                        rep_cnt_d = '0;
                        pulse_req = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!rep_en) begin
                        state_d   = DELAY;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == PER_MAX) begin
                        rep_cnt_d = '0;
                        pulse_req = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = RELEASED;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: reset clears every flop, synchroniser included, so activity
        // in flight when reset hits is discarded rather than resumed.
        if (rst) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            lvl_q     <= 1'b0;
            rep_cnt_q <= '0;
            state_q   <= RELEASED;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, which is what makes the chain a shift register.
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            lvl_q     <= lvl_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
        end
    end

    assign lvl_next = lvl_d;
    assign key_lvl  = lvl_q;

endmodule

// File: rtl/btn_cond_array.sv
// ---------------------------------------------------------------------------
// btn_cond_array
// N_CH conditioned buttons with optional one-hot pulse arbitration.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   btn_in    : raw asynchronous button pins, active-high
//   rep_en    : per-channel auto-repeat enable
//   key_en    : registered one-cycle press/repeat pulses
//   key_lvl   : registered debounced levels
//   any_held  : registered OR of key_lvl (same cycle alignment as key_lvl)
// ---------------------------------------------------------------------------
module btn_cond_array
    import btn_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_PERIOD  = DEF_REP_PERIOD,
    parameter int ONE_HOT     = DEF_ONE_HOT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] rep_en,
    output logic [N_CH-1:0] key_en,
    output logic [N_CH-1:0] key_lvl,
    output logic            any_held
);

    logic [N_CH-1:0] pulse_req;
    logic [N_CH-1:0] lvl_next;
    logic [N_CH-1:0] key_en_q, key_en_d;
    logic            any_held_q, any_held_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        btn_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .REP_DELAY   (REP_DELAY),
            .REP_PERIOD  (REP_PERIOD)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[g]),
            .rep_en    (rep_en[g]),
            .pulse_req (pulse_req[g]),
            .lvl_next  (lvl_next[g]),
            .key_lvl   (key_lvl[g])
        );
    end

    // Lowest-index request wins; losing requests are dropped while their
    // channel FSMs carry on as if delivered.
    always_comb begin
        key_en_d = pulse_req;
        if (ONE_HOT != 0) begin
            key_en_d = pulse_req & (~pulse_req + 1'b1);
        end
        any_held_d = |lvl_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_en_q   <= '0;
            any_held_q <= 1'b0;
        end else begin
            key_en_q   <= key_en_d;
            any_held_q <= any_held_d;
        end
    end

    assign key_en   = key_en_q;
    assign any_held = any_held_q;

endmodule

// File: tb/tb_btn_cond_array.sv
// ---------------------------------------------------------------------------
// tb_btn_cond_array
// Directed bench for btn_cond_array with N_CH=5, SYNC_STAGES=2, DEB_CYCLES=4,
// REP_DELAY=10, REP_PERIOD=3. Two instances share stimulus: ONE_HOT=1 and
// ONE_HOT=0. Inputs change 1 ns after a rising edge; outputs are sampled at
// the same point, so "cycle e" means the value registered on edge e counted
// from the cycle the stimulus was applied.
// ---------------------------------------------------------------------------
module tb_btn_cond_array;

    logic       clk;
    logic       rst;
    logic [4:0] btn_in;
    logic [4:0] rep_en;
    logic [4:0] key_en,  key_lvl;
    logic       any_held;
    logic [4:0] key_en_ind, key_lvl_ind;
    logic       any_held_ind;

    int checks;
    int errors;

    btn_cond_array #(
        .N_CH(5), .SYNC_STAGES(2), .DEB_CYCLES(4),
        .REP_DELAY(10), .REP_PERIOD(3), .ONE_HOT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .rep_en   (rep_en),
        .key_en   (key_en),
        .key_lvl  (key_lvl),
        .any_held (any_held)
    );

    btn_cond_array #(
        .N_CH(5), .SYNC_STAGES(2), .DEB_CYCLES(4),
        .REP_DELAY(10), .REP_PERIOD(3), .ONE_HOT(0)
    ) dut_ind (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .rep_en   (rep_en),
        .key_en   (key_en_ind),
        .key_lvl  (key_lvl_ind),
        .any_held (any_held_ind)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] btn;
        logic [4:0] rep;
        logic [4:0] en;      // expected key_en, ONE_HOT=1
        logic [4:0] lvl;     // expected key_lvl (both instances)
        logic [4:0] en_ind;  // expected key_en, ONE_HOT=0
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input logic [4:0] en,
                           input logic [4:0] lvl, input logic [4:0] en_ind);
        check({tag, " key_en"},       key_en,              en);
        check({tag, " key_lvl"},      key_lvl,             lvl);
        check({tag, " any_held"},     {4'b0, any_held},     {4'b0, |lvl});
        check({tag, " key_en_ind"},   key_en_ind,          en_ind);
        check({tag, " key_lvl_ind"},  key_lvl_ind,         lvl);
        check({tag, " any_held_ind"}, {4'b0, any_held_ind}, {4'b0, |lvl});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [4:0] b, input logic [4:0] r, input logic [4:0] e,
                                input logic [4:0] l, input logic [4:0] ei);
        vec_t v;
        v.btn = b; v.rep = r; v.en = e; v.lvl = l; v.en_ind = ei;
        vecs.push_back(v);
    endfunction

    // Press held for 7 rows then released: pulse and level rise at row 5
    // (edge 6), level falls at row 12 (6 edges after release at row 7).
    function automatic void add_press(input logic [4:0] mask, input logic [4:0] en_oh,
                                      input logic [4:0] en_ind);
        for (int r = 0; r < 14; r++) begin
            add((r < 7) ? mask : 5'b0, 5'b0,
                (r == 5) ? en_oh : 5'b0,
                (r >= 5 && r < 12) ? mask : 5'b0,
                (r == 5) ? en_ind : 5'b0);
        end
    endfunction

    // Drop all inputs and let the level fall; no pulse on release.
    task automatic release_all(input string tag, input logic [4:0] mask);
        btn_in = '0;
        rep_en = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            compare($sformatf("%s release e%0d", tag, k), 5'b0, (k < 6) ? mask : 5'b0, 5'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        btn_in = '0;
        rep_en = '0;

        // Idle rows: rep_en alone does nothing.
        add(5'b0, 5'b11111, 5'b0, 5'b0, 5'b0);
        add(5'b0, 5'b00000, 5'b0, 5'b0, 5'b0);
        add_press(5'b00010, 5'b00010, 5'b00010);  // clean press on channel 1
        add_press(5'b10001, 5'b00001, 5'b10001);  // simultaneous channels 0 and 4

        // Reset state.
        step();
        step();
        compare("reset", 5'b0, 5'b0, 5'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn_in = vecs[i].btn;
            rep_en = vecs[i].rep;
            step();
            compare($sformatf("vec%0d", i), vecs[i].en, vecs[i].lvl, vecs[i].en_ind);
        end

        // Bounce: channel 2 toggles every 2 cycles for 20 cycles, then holds
        // high from cycle 20; one pulse 6 edges later.
        for (int c = 0; c < 28; c++) begin
            btn_in = (c >= 20 || ((c / 2) % 2 == 0)) ? 5'b00100 : 5'b00000;
            step();
            compare($sformatf("bounce e%0d", c + 1),
                    (c + 1 == 26) ? 5'b00100 : 5'b0,
                    (c + 1 >= 26) ? 5'b00100 : 5'b0,
                    (c + 1 == 26) ? 5'b00100 : 5'b0);
        end
        release_all("bounce", 5'b00100);

        // Auto-repeat on channel 3: pulses at 6, 16, 19, 22; rep_en dropped
        // at cycle 23 stops further pulses.
        for (int c = 0; c < 40; c++) begin
            btn_in = 5'b01000;
            rep_en = (c < 23) ? 5'b01000 : 5'b00000;
            step();
            compare($sformatf("repeat e%0d", c + 1),
                    (c + 1 == 6 || c + 1 == 16 || c + 1 == 19 || c + 1 == 22) ? 5'b01000 : 5'b0,
                    (c + 1 >= 6) ? 5'b01000 : 5'b0,
                    (c + 1 == 6 || c + 1 == 16 || c + 1 == 19 || c + 1 == 22) ? 5'b01000 : 5'b0);
        end
        release_all("repeat", 5'b01000);

        // Reset mid-repeat: run to cycle 17, reset for 3 cycles, fresh pulse
        // 6 edges after reset release with the button still held.
        for (int c = 0; c < 17; c++) begin
            btn_in = 5'b01000;
            rep_en = 5'b01000;
            step();
            compare($sformatf("prerst e%0d", c + 1),
                    (c + 1 == 6 || c + 1 == 16) ? 5'b01000 : 5'b0,
                    (c + 1 >= 6) ? 5'b01000 : 5'b0,
                    (c + 1 == 6 || c + 1 == 16) ? 5'b01000 : 5'b0);
        end
        rst = 1'b1;
        #1;
        compare("rst async", 5'b0, 5'b0, 5'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            compare($sformatf("rst held e%0d", k), 5'b0, 5'b0, 5'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            compare($sformatf("postrst e%0d", k),
                    (k == 6) ? 5'b01000 : 5'b0,
                    (k >= 6) ? 5'b01000 : 5'b0,
                    (k == 6) ? 5'b01000 : 5'b0);
        end
        release_all("postrst", 5'b01000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
